imem_boot_loader: RTL and testbench

//  Parametrised instruction memory for the 19-bit CPU, replacing the fixed initial-block program with a run-time loader.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_ram_1r1w.sv | 33 +++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Purpose : shared definitions for the run-time loadable instruction memory
//           of the 19-bit CPU: default geometry, the halt word used for
//           clearing and out-of-range fetches, and the controller states.
// Contents: DEF_DATA_W, DEF_ADDR_W, DEF_DEPTH, DEF_FILL_WORD, state_t
package imem_pkg;

  localparam int DEF_DATA_W = 19;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Halt opcode 5'b11111 in the top bits, all operand bits zero (19'h7C000)
  localparam logic [DEF_DATA_W-1:0] DEF_FILL_WORD = 19'b1111100000000000000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Purpose : DEPTH x DATA_W storage array with one synchronous write port and
//           one registered read port. The read register only updates when
//           re is high, so the last read word is held otherwise.
// Ports   : clk            - clock, rising edge
//           we/waddr/wdata - write enable, address, data
//           re/raddr       - read enable, address
//           rdata          - registered read data
module imem_ram_1r1w #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Purpose : instruction memory with a run-time loader. After reset it fills
//           every word with the halt word, then serves one-cycle registered
//           fetches and accepts load sessions over a valid/ready stream.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           fetch_req/fetch_addr     - fetch request and word address (RUN only)
//           fetch_valid/instruction  - fetched word, valid one cycle later
//           load_start/load_base     - open a load session at a base address
//           load_valid/load_last/
//           load_data/load_ready     - load word stream handshake
//           load_done/load_count     - end-of-session pulse, words written
//           busy                     - high while clearing or loading
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter logic [DATA_W-1:0] FILL_WORD = DEF_FILL_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              busy
);

  // One extra bit so DEPTH itself is representable for range compares
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_LAST  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state, next_state;
  logic [ADDR_W:0]   ptr, ptr_next;
  logic [ADDR_W:0]   count_next;
  logic              done_next;
  logic              fetch_accept;
  logic              fetch_oor;
  logic              base_oor;
  logic              use_fill;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign fetch_oor = {1'b0, fetch_addr} >= DEPTH_EXT;
  assign base_oor  = {1'b0, load_base} >= DEPTH_EXT;
  assign ram_re    = fetch_accept && !fetch_oor;

  assign load_ready = (state == LOAD);
  assign busy       = (state != RUN);

  // use_fill covers both the reset value and out-of-range fetches, so the
  // RAM read register never needs a reset of its own.
  assign instruction = use_fill ? FILL_WORD : ram_rdata;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      use_fill    <= 1'b1;
    end else begin
      state       <= next_state;
      ptr         <= ptr_next;
      load_count  <= count_next;
      load_done   <= done_next;
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        use_fill <= fetch_oor;
      end
    end
  end

  // Next-state, pointer and write-port control. The load session ends on an
  // accepted last word or on the write to the top word, never wrapping.
  always_comb begin
    next_state   = state;
    ptr_next     = ptr;
    count_next   = load_count;
    done_next    = 1'b0;
    fetch_accept = 1'b0;
    ram_we       = 1'b0;
    ram_wdata    = load_data;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = FILL_WORD;
        ptr_next  = ptr + 1'b1;
        if (ptr == PTR_LAST) begin
          next_state = RUN;
          ptr_next   = '0;
        end
      end
      RUN: begin
        fetch_accept = fetch_req;
        if (load_start) begin
          count_next = '0;
          if (base_oor) begin
            done_next = 1'b1;
          end else begin
            next_state = LOAD;
            ptr_next   = {1'b0, load_base};
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          ram_we     = 1'b1;
          ptr_next   = ptr + 1'b1;
          count_next = load_count + 1'b1;
          if (load_last || ptr == PTR_LAST) begin
            next_state = RUN;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        next_state = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  imem_ram_1r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ptr[ADDR_W-1:0]),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(fetch_addr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: clear after reset, load sessions,
// fetches while loading, top-of-memory truncation, reset mid-load and a
// simultaneous fetch/load_start.
module tb_imem_boot_loader;

  localparam logic [18:0] FILL = 19'h7C000;
  localparam logic [18:0] W0   = 19'h28008;
  localparam logic [18:0] W1   = 19'h12345;
  localparam logic [18:0] W2   = 19'h00001;
  localparam logic [18:0] W3   = 19'h0ABCD;
  localparam logic [18:0] WA   = 19'h11111;
  localparam logic [18:0] WB   = 19'h22222;
  localparam logic [18:0] WC   = 19'h33333;
  localparam logic [18:0] WD   = 19'h44444;
  localparam logic [18:0] W6   = 19'h55555;
  localparam logic [18:0] W5   = 19'h66666;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_valid;
  logic [18:0] instruction;
  logic        load_start;
  logic [7:0]  load_base;
  logic        load_valid;
  logic        load_last;
  logic [18:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [8:0]  load_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .instruction(instruction),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .busy       (busy)
  );

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    checkOutput({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
    checkOutput({tag, ".instruction"}, 32'(instruction), 32'(FILL));
    checkOutput({tag, ".load_ready"}, 32'(load_ready), 32'd0);
    checkOutput({tag, ".load_done"}, 32'(load_done), 32'd0);
    checkOutput({tag, ".load_count"}, 32'(load_count), 32'd0);
  endtask

  // Count cycles until busy drops, bounded so a stuck DUT still ends the run
  task automatic waitClear(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, ".clear_cycles"}, 32'(n), 32'd256);
  endtask

  task automatic fetchCheck(input string tag, input logic [7:0] addr, input logic [18:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    applyStimulus();
    checkOutput({tag, ".valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({tag, ".instr"}, 32'(instruction), 32'(exp));
  endtask

  task automatic pushWord(input logic [18:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    applyStimulus();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;

    // Reset and clear
    applyStimulus();
    rst = 1'b0;
    checkResetValues("reset");
    waitClear("t1");
    fetchCheck("t1.fetch05", 8'h05, FILL);
    fetch_req = 1'b0;
    applyStimulus();
    checkOutput("t1.idle_valid", 32'(fetch_valid), 32'd0);
    checkOutput("t1.hold_instr", 32'(instruction), 32'(FILL));

    // Three-word load at base 0
    load_start = 1'b1; load_base = 8'h00;
    applyStimulus();
    load_start = 1'b0;
    checkOutput("t2.ready", 32'(load_ready), 32'd1);
    checkOutput("t2.busy", 32'(busy), 32'd1);
    checkOutput("t2.count0", 32'(load_count), 32'd0);
    pushWord(W0, 1'b0);
    pushWord(W1, 1'b0);
    checkOutput("t2.done_early", 32'(load_done), 32'd0);
    pushWord(W2, 1'b1);
    checkOutput("t2.done", 32'(load_done), 32'd1);
    checkOutput("t2.ready_drop", 32'(load_ready), 32'd0);
    checkOutput("t2.count", 32'(load_count), 32'd3);
    checkOutput("t2.busy_run", 32'(busy), 32'd0);
    fetchCheck("t2.f0", 8'h00, W0);
    checkOutput("t2.done_once", 32'(load_done), 32'd0);
    fetchCheck("t2.f1", 8'h01, W1);
    fetchCheck("t2.f2", 8'h02, W2);
    fetch_req = 1'b0;
    applyStimulus();

    // fetch_req held through a LOAD session
    load_start = 1'b1; load_base = 8'h10;
    applyStimulus();
    load_start = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'h10;
    load_valid = 1'b1; load_data = W3; load_last = 1'b1;
    applyStimulus();
    load_valid = 1'b0; load_last = 1'b0;
    checkOutput("t3.no_valid", 32'(fetch_valid), 32'd0);
    checkOutput("t3.done", 32'(load_done), 32'd1);
    checkOutput("t3.count", 32'(load_count), 32'd1);
    applyStimulus();
    checkOutput("t3.valid", 32'(fetch_valid), 32'd1);
    checkOutput("t3.instr", 32'(instruction), 32'(W3));
    fetch_req = 1'b0;
    applyStimulus();

    // Base near the top: only two words fit
    load_start = 1'b1; load_base = 8'hFE;
    applyStimulus();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = WA;
    applyStimulus();
    checkOutput("t4.ready1", 32'(load_ready), 32'd1);
    load_data = WB;
    applyStimulus();
    checkOutput("t4.ready_drop", 32'(load_ready), 32'd0);
    checkOutput("t4.done", 32'(load_done), 32'd1);
    checkOutput("t4.count", 32'(load_count), 32'd2);
    load_data = WC;
    applyStimulus();
    load_data = WD;
    applyStimulus();
    load_valid = 1'b0;
    checkOutput("t4.count_hold", 32'(load_count), 32'd2);
    checkOutput("t4.ready_off", 32'(load_ready), 32'd0);
    fetchCheck("t4.fFE", 8'hFE, WA);
    fetchCheck("t4.fFF", 8'hFF, WB);
    fetchCheck("t4.f00", 8'h00, W0);
    fetch_req = 1'b0;
    applyStimulus();

    // Fetch and load_start together: old word served, then LOAD
    fetch_req = 1'b1; fetch_addr = 8'h00;
    load_start = 1'b1; load_base = 8'h00;
    applyStimulus();
    fetch_req = 1'b0; load_start = 1'b0;
    checkOutput("t6.valid", 32'(fetch_valid), 32'd1);
    checkOutput("t6.instr", 32'(instruction), 32'(W0));
    checkOutput("t6.ready", 32'(load_ready), 32'd1);
    pushWord(W6, 1'b1);
    applyStimulus();
    fetchCheck("t6.new", 8'h00, W6);
    fetch_req = 1'b0;
    applyStimulus();

    // Reset during LOAD after one word
    load_start = 1'b1; load_base = 8'h40;
    applyStimulus();
    load_start = 1'b0;
    pushWord(W5, 1'b0);
    checkOutput("t5.count1", 32'(load_count), 32'd1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkResetValues("t5");
    waitClear("t5");
    for (int a = 0; a < 256; a++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(a);
      applyStimulus();
      checkOutput($sformatf("t5.mem%02h", a), 32'(instruction), 32'(FILL));
    end
    fetch_req = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
